// File: rtl/r5p_pkg.sv
// ----------------------------------------------------------------------------
// r5p_pkg
// Shared types for the r5p load/store bus.
//   bus_req_t   : one bus request as the initiator presents it
//   rsp_state_t : responder wait-state sequencer states
// ----------------------------------------------------------------------------
package r5p_pkg;

   localparam int unsigned R5P_AW = 32;
   localparam int unsigned R5P_DW = 32;
   localparam int unsigned R5P_BW = R5P_DW / 8;

   typedef struct packed {
      logic              wen;
      logic [R5P_AW-1:0] adr;
      logic [R5P_BW-1:0] ben;
      logic [R5P_DW-1:0] wdt;
   } bus_req_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STALL = 2'd1,
      READY = 2'd2
   } rsp_state_t;

endpackage : r5p_pkg

// File: rtl/r5p_bus_rsp_ram.sv
// ----------------------------------------------------------------------------
// r5p_bus_rsp_ram
// Single-port byte-enabled word RAM with a registered read port.
//   clk  : clock
//   rst  : asynchronous reset, active-low (clears only the read register)
//   we   : write strobe, bytes selected by ben take wdt
//   re   : read strobe, loads the read register
//   rz   : with re, load zero instead of the array word (unmapped read)
//   idx  : word index
//   ben  : byte enables for writes
//   wdt  : write data
//   rdt  : read data, holds between read strobes
// ----------------------------------------------------------------------------
module r5p_bus_rsp_ram #(
   parameter int unsigned DW    = 32,
   parameter int unsigned BW    = DW / 8,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned IW    = $clog2(DEPTH),
   parameter string       CHIP  = ""
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic          re,
   input  logic          rz,
   input  logic [IW-1:0] idx,
   input  logic [BW-1:0] ben,
   input  logic [DW-1:0] wdt,
   output logic [DW-1:0] rdt
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdt_q;
   logic [DW-1:0] rdt_d;

   // No vendor macro wrappers exist yet, so a named device falls back to the
   // same inferable array; the selection point stays here for later use.
   generate
      if (CHIP == "") begin : g_generic
         // Byte-enabled write into the generic array.
         always_ff @(posedge clk) begin
            if (we) begin
               for (int i = 0; i < int'(BW); i++) begin
                  if (ben[i]) begin
                     mem_q[idx][8*i +: 8] <= wdt[8*i +: 8];
                  end
               end
            end
         end
      end else begin : g_vendor
         // Byte-enabled write into the array for a named device.
         always_ff @(posedge clk) begin
            if (we) begin
               for (int i = 0; i < int'(BW); i++) begin
                  if (ben[i]) begin
                     mem_q[idx][8*i +: 8] <= wdt[8*i +: 8];
                  end
               end
            end
         end
      end
   endgenerate

   // Next read-register value: only a read strobe changes it.
   always_comb begin
      rdt_d = rdt_q;
      if (re) begin
         if (rz) begin
            rdt_d = {DW{1'b0}};
         end else begin
            rdt_d = mem_q[idx];
         end
      end else begin
         rdt_d = rdt_q;
      end
   end

   // Read register with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdt_q <= {DW{1'b0}};
      end else begin
         rdt_q <= rdt_d;
      end
   end

   assign rdt = rdt_q;

endmodule : r5p_bus_rsp_ram

// File: rtl/r5p_bus_rsp.sv
// ----------------------------------------------------------------------------
// r5p_bus_rsp
// Memory-side responder for the r5p vld/rdy load/store bus. Decodes the byte
// address, inserts WAIT wait states per request, writes with byte enables and
// returns read data one cycle after the read handshake.
//   clk : clock                    rst : asynchronous reset, active-low
//   vld : request valid            wen : 1 write, 0 read
//   adr : byte address             ben : byte enables (writes only)
//   wdt : write data               rdt : read data (valid after read xfer)
//   rdy : ready, transfer = vld & rdy
// ----------------------------------------------------------------------------
module r5p_bus_rsp
   import r5p_pkg::*;
#(
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 32,
   parameter int unsigned BW   = DW / 8,
   parameter int unsigned SIZE = 4096,
   parameter int unsigned WAIT = 0,
   parameter string       CHIP = ""
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          vld,
   input  logic          wen,
   input  logic [AW-1:0] adr,
   input  logic [BW-1:0] ben,
   input  logic [DW-1:0] wdt,
   output logic [DW-1:0] rdt,
   output logic          rdy
);

   localparam int unsigned MW = $clog2(SIZE);   // bits addressing the memory
   localparam int unsigned OW = $clog2(BW);     // byte-within-word bits
   localparam int unsigned IW = MW - OW;        // word index bits

   logic          rdy_s;
   logic          xfer_s;
   logic          oob_s;
   logic [IW-1:0] idx_s;
   logic          unused_s;

   assign idx_s    = adr[MW-1:OW];
   assign unused_s = ^adr[OW-1:0];
   assign xfer_s   = vld & rdy_s;

   // Any set bit above the memory span means the address is unmapped.
   generate
      if (AW > MW) begin : g_oob
         assign oob_s = |adr[AW-1:MW];
      end else begin : g_no_oob
         assign oob_s = 1'b0;
      end
   endgenerate

   generate
      if (WAIT == 0) begin : g_nowait
         assign rdy_s = 1'b1;
      end else begin : g_wait
         localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

         rsp_state_t state_q;
         rsp_state_t state_d;
         logic [3:0] cnt_q;
         logic [3:0] cnt_d;

         // Wait-state sequencer: IDLE and STALL together last WAIT cycles.
         // cnt counts remaining STALL cycles; it reaches 0 as READY is entered.
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
               IDLE: begin
                  if (vld) begin
                     if (WAIT == 1) begin
                        state_d = READY;
                        cnt_d   = 4'd0;
                     end else begin
                        state_d = STALL;
                        cnt_d   = CNT_LOAD;
                     end
                  end else begin
                     state_d = IDLE;
                     cnt_d   = 4'd0;
                  end
               end
               STALL: begin
                  if (!vld) begin
                     // Initiator withdrew: abandon without a memory access.
                     state_d = IDLE;
                     cnt_d   = 4'd0;
                  end else begin
                     cnt_d = cnt_q - 4'd1;
                     if (cnt_q == 4'd1) begin
                        state_d = READY;
                     end else begin
                        state_d = STALL;
                     end
                  end
               end
               READY: begin
                  // Always return to IDLE so the next request waits in full.
                  state_d = IDLE;
                  cnt_d   = 4'd0;
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
               end
            endcase
         end

         // Sequencer state and counter registers.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_q <= IDLE;
               cnt_q   <= 4'd0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
            end
         end

         assign rdy_s = (state_q == READY);
      end
   endgenerate

   r5p_bus_rsp_ram #(
      .DW    (DW),
      .BW    (BW),
      .DEPTH (SIZE / BW),
      .IW    (IW),
      .CHIP  (CHIP)
   ) u_ram (
      .clk (clk),
      .rst (rst),
      .we  (xfer_s &  wen & ~oob_s),
      .re  (xfer_s & ~wen),
      .rz  (oob_s),
      .idx (idx_s),
      .ben (ben),
      .wdt (wdt),
      .rdt (rdt)
   );

   assign rdy = rdy_s;

endmodule : r5p_bus_rsp

// File: tb/tb_r5p_bus_rsp.sv
// ----------------------------------------------------------------------------
// tb_r5p_bus_rsp
// Three responders (WAIT = 0, 2, 3) driven one at a time. A request-level
// model predicts rdy/rdt and is compared on every falling edge; directed
// checks pin the model with hand-computed literals.
// ----------------------------------------------------------------------------
module tb_r5p_bus_rsp;

   logic        clk;
   logic        rst;
   logic        vld [3];
   logic        wen [3];
   logic [31:0] adr [3];
   logic [3:0]  ben [3];
   logic [31:0] wdt [3];
   logic [31:0] rdt [3];
   logic        rdy [3];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit chk_en      = 1'b0;

   r5p_bus_rsp #(.WAIT(0)) u_w0 (
      .clk(clk), .rst(rst), .vld(vld[0]), .wen(wen[0]), .adr(adr[0]),
      .ben(ben[0]), .wdt(wdt[0]), .rdt(rdt[0]), .rdy(rdy[0]));
   r5p_bus_rsp #(.WAIT(2)) u_w2 (
      .clk(clk), .rst(rst), .vld(vld[1]), .wen(wen[1]), .adr(adr[1]),
      .ben(ben[1]), .wdt(wdt[1]), .rdt(rdt[1]), .rdy(rdy[1]));
   r5p_bus_rsp #(.WAIT(3)) u_w3 (
      .clk(clk), .rst(rst), .vld(vld[2]), .wen(wen[2]), .adr(adr[2]),
      .ben(ben[2]), .wdt(wdt[2]), .rdt(rdt[2]), .rdy(rdy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // ---------------- request-level model ----------------
   function automatic int wt(input int k);
      case (k)
         0:       return 0;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   // age = cycles the current request has already waited with vld high
   int          age [3];
   bit   [31:0] exp_rdt [3];
   logic [31:0] mdl_mem [int];

   function automatic bit exp_rdy(input int k);
      return (wt(k) == 0) ? 1'b1 : (age[k] == wt(k));
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            age[k]     = 0;
            exp_rdt[k] = 32'h0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            bit          go;
            int          key;
            logic [31:0] w;
            go  = vld[k] && exp_rdy(k);
            key = k * 1024 + int'(adr[k][11:2]);
            if (go) begin
               if (wen[k]) begin
                  if (adr[k] < 32'd4096) begin
                     w = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
                     for (int i = 0; i < 4; i++)
                        if (ben[k][i]) w[8*i +: 8] = wdt[k][8*i +: 8];
                     mdl_mem[key] = w;
                  end
               end else begin
                  exp_rdt[k] = (adr[k] < 32'd4096) ? mdl_mem[key] : 32'h0;
               end
            end
            if (wt(k) == 0 || age[k] == wt(k) || !vld[k]) age[k] = 0;
            else                                          age[k] = age[k] + 1;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (rdy[k] !== exp_rdy(k)) begin
               $display("FAIL cyc_rdy dut=%0d t=%0t got %b required %b", k, $time, rdy[k], exp_rdy(k));
               miscompares++;
            end
            vectors++;
            if (rdt[k] !== exp_rdt[k]) begin
               $display("FAIL cyc_rdt dut=%0d t=%0t got %h required %h", k, $time, rdt[k], exp_rdt[k]);
               miscompares++;
            end
         end
      end
   end

   // Initiator stability: a waiting request may not change or be withdrawn.
   logic        pend [3];
   logic        pw   [3];
   logic [31:0] pa   [3];
   logic [3:0]  pb   [3];
   logic [31:0] pd   [3];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) pend[k] = 1'b0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (pend[k])
               assert (vld[k] && wen[k] == pw[k] && adr[k] == pa[k] &&
                       ben[k] == pb[k] && wdt[k] == pd[k])
               else $error("protocol: dut %0d request changed while waiting", k);
            pend[k] = vld[k] && !rdy[k];
            pw[k] = wen[k]; pa[k] = adr[k]; pb[k] = ben[k]; pd[k] = wdt[k];
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         $display("FAIL %s: got %h required %h", nm, act, req);
         miscompares++;
      end
   endtask

   // Present a request and wait for its handshake; returns at the next
   // mid-cycle point after the transfer edge with vld still high.
   task automatic xfer(input int k, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, output int lowc);
      bit done;
      done = 1'b0;
      lowc = 0;
      vld[k] = 1'b1; wen[k] = w; adr[k] = a; ben[k] = b; wdt[k] = d;
      for (int n = 0; n < 40; n++) begin
         if (rdy[k]) begin
            @(negedge clk); #1;
            done = 1'b1;
            break;
         end
         lowc++;
         @(negedge clk); #1;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL handshake_timeout dut=%0d adr=%h: got no rdy required rdy=1", k, a);
      end
   endtask

   task automatic idle(input int k);
      vld[k] = 1'b0;
      @(negedge clk); #1;
   endtask

   int lc;
   int c0;

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vld[k] = 1'b0; wen[k] = 1'b0; adr[k] = 32'h0; ben[k] = 4'h0; wdt[k] = 32'h0;
      end
      #2 rst = 1'b0;
      #1;
      chk_en = 1'b1;
      chk("reset_rdt0", rdt[0], 32'h0);
      chk("reset_rdt2", rdt[1], 32'h0);
      chk("reset_rdt3", rdt[2], 32'h0);
      chk("reset_rdy0", 32'(rdy[0]), 32'h1);
      chk("reset_rdy2", 32'(rdy[1]), 32'h0);
      chk("reset_rdy3", 32'(rdy[2]), 32'h0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk); #1;

      // WAIT=0: write then immediate read of the same word
      xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lc); chk("w0_wr_low", 32'(lc), 32'd0);
      xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, lc);        chk("w0_rd_low", 32'(lc), 32'd0);
      chk("w0_rd_data", rdt[0], 32'hDEADBEEF);
      xfer(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, lc);
      idle(0);
      chk("w0_hold_over_write", rdt[0], 32'hDEADBEEF);

      // WAIT=0: partial byte write merge
      xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344, lc);
      xfer(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, lc);
      xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, lc);
      chk("w0_ben_merge", rdt[0], 32'h11BB33DD);
      xfer(0, 1'b0, 32'h23, 4'h0, 32'h0, lc);
      chk("w0_low_bits_ignored", rdt[0], 32'h11BB33DD);

      // Out of range
      xfer(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, lc);
      xfer(0, 1'b0, 32'h1000, 4'h0, 32'h0, lc);
      chk("oob_read_zero", rdt[0], 32'h0);
      xfer(0, 1'b0, 32'h0, 4'h0, 32'h0, lc);
      chk("oob_word0_intact", rdt[0], 32'hCAFEF00D);
      xfer(0, 1'b0, 32'h1010, 4'h0, 32'h0, lc);
      chk("oob_alias_zero", rdt[0], 32'h0);
      idle(0);

      // WAIT=3: single write, single read
      xfer(2, 1'b1, 32'h40, 4'hF, 32'h0BADF00D, lc); chk("w3_wr_low", 32'(lc), 32'd3);
      idle(2);
      xfer(2, 1'b0, 32'h40, 4'h0, 32'h0, lc);        chk("w3_rd_low", 32'(lc), 32'd3);
      chk("w3_rd_data", rdt[2], 32'h0BADF00D);
      idle(2);
      xfer(2, 1'b1, 32'h44, 4'hF, 32'h44444444, lc);
      xfer(2, 1'b1, 32'h48, 4'hF, 32'h48484848, lc);
      xfer(2, 1'b1, 32'h4C, 4'hF, 32'h4C4C4C4C, lc);
      idle(2);

      // WAIT=3: four back-to-back reads
      c0 = cyc;
      xfer(2, 1'b0, 32'h40, 4'h0, 32'h0, lc);
      xfer(2, 1'b0, 32'h44, 4'h0, 32'h0, lc);
      chk("w3_b2b_second", rdt[2], 32'h44444444);
      xfer(2, 1'b0, 32'h48, 4'h0, 32'h0, lc);
      xfer(2, 1'b0, 32'h4C, 4'h0, 32'h0, lc);
      chk("w3_b2b_cycles", 32'(cyc - c0), 32'd16);
      chk("w3_b2b_last", rdt[2], 32'h4C4C4C4C);
      idle(2);

      // WAIT=2: reset while a write is stalled
      xfer(1, 1'b1, 32'h80, 4'hF, 32'h5A5AA5A5, lc); chk("w2_wr_low", 32'(lc), 32'd2);
      xfer(1, 1'b0, 32'h80, 4'h0, 32'h0, lc);        chk("w2_rd_low", 32'(lc), 32'd2);
      chk("w2_rd_data", rdt[1], 32'h5A5AA5A5);
      idle(1);
      vld[1] = 1'b1; wen[1] = 1'b1; adr[1] = 32'h80; ben[1] = 4'hF; wdt[1] = 32'hFFFF0000;
      @(negedge clk); #1;
      chk("w2_stall_rdy", 32'(rdy[1]), 32'h0);
      rst = 1'b0;
      #1;
      chk("w2_rst_rdt", rdt[1], 32'h0);
      chk("w2_rst_rdy", 32'(rdy[1]), 32'h0);
      chk("w2_rst_rdt_other", rdt[2], 32'h0);
      @(negedge clk); #1;
      vld[1] = 1'b0;
      @(negedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      xfer(1, 1'b0, 32'h80, 4'h0, 32'h0, lc);        chk("w2_post_rst_low", 32'(lc), 32'd2);
      chk("w2_write_dropped", rdt[1], 32'h5A5AA5A5);
      idle(1);
      idle(1);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_r5p_bus_rsp

// File: doc/r5p_bus_rsp.md
Name: r5p_bus_rsp

Overview:
Load/store bus responder: the memory end of the vld/rdy data bus that the r5p core drives (ls_* signals).
- Decodes each request, applies a configurable number of wait states, and performs byte-enabled writes into an internal word RAM.
- Returns read data one cycle after the read handshake, which matches the core's delayed load writeback.
- Used as the data memory in r5p SoC tops and as the bus model in core benches.

Parameters:
AW, 32, request address width (byte address)
DW, 32, data width
BW, DW/8, byte enable width
SIZE, 4096, memory size in bytes; power of two, multiple of BW
WAIT, 0, wait states inserted before rdy per request (0..15)
CHIP, "", implementation device selector, passed to the RAM sub-module

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
vld  input  1  request valid
wen  input  1  write enable (1 write, 0 read)
adr  input  AW  byte address
ben  input  BW  byte enable
wdt  input  DW  write data
rdt  output  DW  read data
rdy  output  1  request ready; transfer = vld & rdy

Behaviour:
Reset values (rst low, async):
- rdt = 0, state = IDLE, wait counter = 0.
- rdy = 1 if WAIT==0, else 0.
- RAM contents are not reset.

Transfer: occurs in any cycle with vld & rdy. At most one transfer per cycle; back-to-back transfers are allowed.

Address decode:
- Word index = adr[$clog2(SIZE)-1:$clog2(BW)]; low address bits are ignored.
- adr >= SIZE is out of range: writes are dropped and reads return 0.

Write transfer:
- On the transfer edge, each byte i with ben[i]=1 takes wdt[8i+7:8i]; bytes with ben[i]=0 are unchanged.
- rdt is not modified.

Read transfer:
- rdt is updated at the transfer edge with the full addressed word; ben is ignored for reads.
- Read latency is 1: data is valid the cycle after the handshake.
- rdt then holds until the next read transfer, including across writes and idle cycles.

WAIT==0:
- rdy is constant 1 and no FSM is used; full throughput of one transfer per cycle.

WAIT>0, FSM:
- IDLE: rdy=0. On vld=1, load cnt=WAIT-1 and go to STALL, or go directly to READY when WAIT==1.
- STALL: rdy=0. Decrement cnt each cycle; when cnt==0, go to READY.
- READY: rdy=1 and the transfer occurs.
  - Next cycle goes to IDLE, so every request sees exactly WAIT cycles with rdy low.
  - Back-to-back requests therefore cost WAIT+1 cycles each.
- vld dropping in STALL or READY is a protocol violation: return to IDLE with no memory access. The bench flags it with an assertion.

Initiator rule: while vld & ~rdy, the initiator holds wen/adr/ben/wdt stable. The responder samples them only on the transfer cycle, and the bench checks this with an assertion.

Reset mid-operation: the FSM goes to IDLE and rdt is cleared. A pending write is not performed unless its transfer edge completed before rst fell.

Simultaneous events: a read following a write to the same word in the next cycle returns the new data, because the write is complete at its edge.

Decomposition:
- r5p_pkg (shared) gets:
  - bus_req_t struct {wen, adr, ben, wdt};
  - rsp_state_t enum {IDLE, STALL, READY}.
- Sub-module r5p_bus_rsp_ram:
  - single-port byte-enabled RAM: DEPTH=SIZE/BW, sync write, sync read registered into rdt, read-enable gated;
  - holds the CHIP selection for vendor RAM inference.
- r5p_bus_rsp keeps the decode, FSM and wait counter.

Test Plan:
- WAIT=0: write adr 0x10, ben 4'b1111, wdt 0xDEADBEEF, then read 0x10 -> rdy stays 1 throughout; rdt=0xDEADBEEF in the cycle after the read handshake.
- WAIT=0: write 0x20=0x11223344, then write 0x20 ben 4'b0101 wdt 0xAABBCCDD, then read 0x20 -> rdt=0x11BB33DD.
- WAIT=3: single read -> rdy low for exactly 3 cycles after vld rises, high in cycle 4; rdt valid in cycle 5.
- WAIT=3: 4 back-to-back reads -> 16 cycles in total; rdt holds its value between transfers.
- Out of range: write adr=SIZE wdt 0xFFFFFFFF, then read adr=SIZE -> rdt=0; a read of adr 0 is unaffected.
- WAIT=2: assert rst (low) while in STALL -> rdt=0 and rdy=0 immediately; after release, a read of previously written data returns the old value.
